// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives start/a/b; the slave returns status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell per clock.
// Results are registered at the last bit and held until the next one.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_bin;
  logic             r_amsb;
  logic             r_bmsb;
  logic             r_bout;
  logic             r_ovf;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_res;

  assign w_x      = r_sa[0];
  assign w_y      = r_sb[0];
  assign w_d      = w_x ^ w_y ^ r_bin;
  assign w_bout   = (~w_x & w_y) | (~(w_x ^ w_y) & r_bin);
  assign w_last   = (r_cnt == LAST);
  assign w_accept = (r_state == S_IDLE) && bus.start;

  // Result bits enter at the MSB so the word is aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res1
      assign w_res = w_d;
    end else begin : g_resn
      assign w_res = {w_d, r_res[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_res  <= '0;
      r_diff <= '0;
      r_cnt  <= '0;
      r_bin  <= 1'b0;
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_sa   <= bus.a;
      r_sb   <= bus.b;
      r_bin  <= 1'b0;
      r_cnt  <= '0;
      r_amsb <= bus.a[WIDTH-1];
      r_bmsb <= bus.b[WIDTH-1];
    end else if (r_state == S_RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_res <= w_res;
      r_bin <= w_bout;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= w_res;
        r_bout <= w_bout;
        r_ovf  <= (r_amsb != r_bmsb) && (w_res[WIDTH-1] != r_amsb);
      end
    end
  end

  assign bus.busy       = (r_state == S_RUN);
  assign bus.done       = (r_state == S_DONE);
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_bout;
  assign bus.ovf        = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 instances vs an arithmetic model.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(1)) if1 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  logic [7:0] dir_a [4] = '{8'h5A, 8'h00, 8'h80, 8'h7F};
  logic [7:0] dir_b [4] = '{8'h3C, 8'h01, 8'h01, 8'hFF};
  logic [9:0] dir_r [4] = '{{8'h1E, 2'b00}, {8'hFF, 2'b10},
                            {8'h7F, 2'b01}, {8'h80, 2'b11}};

  function automatic logic [9:0] model8(input logic [7:0] a,
                                        input logic [7:0] b);
    int         sd;
    logic [7:0] d;
    sd = int'($signed(a)) - int'($signed(b));
    d  = a - b;
    return {d, (a < b), (sd > 127) || (sd < -128)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busyc);
    if8.start = 1'b1;
    if8.a     = a;
    if8.b     = b;
    tick();
    if8.start = 1'b0;
    if8.a     = 8'($urandom);
    if8.b     = 8'($urandom);
    lat   = 0;
    busyc = 0;
    while (!if8.done && lat < 40) begin
      if (if8.busy) busyc++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    logic [11:0] got;
    rst       = 1'b1;
    if8.start = 1'b1;
    if8.a     = 8'h12;
    if8.b     = 8'h34;
    tick();
    tick();
    got = {if8.busy, if8.done, if8.diff, if8.borrow_out, if8.ovf};
    checks++;
    if (got !== 12'h000) begin
      errors++;
      $display("FAIL reset8 got %h exp %h", got, 12'h000);
    end
    checks++;
    if ({if1.busy, if1.done, if1.diff, if1.borrow_out, if1.ovf} !== 5'b0) begin
      errors++;
      $display("FAIL reset1 got %b exp 00000",
               {if1.busy, if1.done, if1.diff, if1.borrow_out, if1.ovf});
    end
    rst       = 1'b0;
    if8.start = 1'b0;
    tick();
    checks++;
    if (if8.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy got %b exp 0", if8.busy);
    end
  endtask

  task automatic test_directed();
    int lat;
    int bc;
    for (int i = 0; i < 4; i++) begin
      do_op8(dir_a[i], dir_b[i], lat, bc);
      checks++;
      if (lat !== 8 || bc !== 8) begin
        errors++;
        $display("FAIL dir_latency[%0d] got lat=%0d busy=%0d exp 8 8",
                 i, lat, bc);
      end
      checks++;
      if ({if8.diff, if8.borrow_out, if8.ovf} !== dir_r[i]) begin
        errors++;
        $display("FAIL dir_result[%0d] got %h exp %h", i,
                 {if8.diff, if8.borrow_out, if8.ovf}, dir_r[i]);
      end
      tick();
      checks++;
      if (if8.done !== 1'b0) begin
        errors++;
        $display("FAIL dir_pulse[%0d] done got %b exp 0", i, if8.done);
      end
    end
  endtask

  task automatic test_ignore();
    int cyc;
    int dn;
    logic busy_after;
    if8.start = 1'b1;
    if8.a     = 8'h10;
    if8.b     = 8'h01;
    tick();
    cyc = 0;
    while (!if8.done && cyc < 40) begin
      if8.a = (cyc == 0) ? 8'hFF : 8'($urandom);
      if8.b = (cyc == 0) ? 8'h00 : 8'($urandom);
      tick();
      cyc++;
    end
    if8.start  = 1'b0;
    dn         = if8.done ? 1 : 0;
    checks++;
    if ({if8.diff, if8.borrow_out, if8.ovf} !== {8'h0F, 2'b00}) begin
      errors++;
      $display("FAIL ignore_result got %h exp %h",
               {if8.diff, if8.borrow_out, if8.ovf}, {8'h0F, 2'b00});
    end
    busy_after = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (if8.done) dn++;
      if (if8.busy) busy_after = 1'b1;
    end
    checks++;
    if (dn !== 1 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL ignore_once got done=%0d busy=%b exp 1 0",
               dn, busy_after);
    end
  endtask

  task automatic test_abort();
    int   lat;
    int   bc;
    int   dn;
    if8.start = 1'b1;
    if8.a     = 8'h33;
    if8.b     = 8'h11;
    tick();
    if8.start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (if8.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_run busy got %b exp 1", if8.busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({if8.busy, if8.done, if8.diff, if8.borrow_out, if8.ovf} !== 12'h000) begin
      errors++;
      $display("FAIL abort_clear got %h exp 000",
               {if8.busy, if8.done, if8.diff, if8.borrow_out, if8.ovf});
    end
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (if8.done || if8.busy) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d active cycles exp 0", dn);
    end
    do_op8(8'h33, 8'h11, lat, bc);
    checks++;
    if ({if8.diff, if8.borrow_out, if8.ovf} !== {8'h22, 2'b00} || lat !== 8) begin
      errors++;
      $display("FAIL abort_restart got %h lat %0d exp %h lat 8",
               {if8.diff, if8.borrow_out, if8.ovf}, lat, {8'h22, 2'b00});
    end
    tick();
  endtask

  task automatic test_random();
    int         lat;
    int         bc;
    logic [7:0] a;
    logic [7:0] b;
    logic [9:0] exp;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      b = (i == 0) ? a : 8'($urandom);
      exp = model8(a, b);
      do_op8(a, b, lat, bc);
      checks++;
      if ({if8.diff, if8.borrow_out, if8.ovf} !== exp || lat !== 8) begin
        errors++;
        $display("FAIL random a=%h b=%h got %h lat %0d exp %h lat 8",
                 a, b, {if8.diff, if8.borrow_out, if8.ovf}, lat, exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic       pb;
    logic       have_acc;
    logic       have_res;
    int         last_acc;
    int         ndone;
    logic [7:0] da;
    logic [7:0] db;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [9:0] held;
    logic [9:0] exp;
    pb       = 1'b0;
    have_acc = 1'b0;
    have_res = 1'b0;
    last_acc = 0;
    ndone    = 0;
    ea       = '0;
    eb       = '0;
    held     = '0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      da        = 8'($urandom);
      db        = 8'($urandom);
      if8.a     = da;
      if8.b     = db;
      if8.start = 1'b1;
      tick();
      if (if8.busy && !pb) begin
        ea = da;
        eb = db;
        if (have_acc) begin
          checks++;
          if (cyc - last_acc !== 10) begin
            errors++;
            $display("FAIL b2b_period got %0d exp 10", cyc - last_acc);
          end
        end
        last_acc = cyc;
        have_acc = 1'b1;
      end
      if (if8.done) begin
        exp = model8(ea, eb);
        checks++;
        if ({if8.diff, if8.borrow_out, if8.ovf} !== exp) begin
          errors++;
          $display("FAIL b2b_result a=%h b=%h got %h exp %h", ea, eb,
                   {if8.diff, if8.borrow_out, if8.ovf}, exp);
        end
        held     = exp;
        have_res = 1'b1;
        ndone++;
      end else if (have_res) begin
        checks++;
        if ({if8.diff, if8.borrow_out, if8.ovf} !== held) begin
          errors++;
          $display("FAIL b2b_hold got %h exp %h",
                   {if8.diff, if8.borrow_out, if8.ovf}, held);
        end
      end
      pb = if8.busy;
    end
    if8.start = 1'b0;
    checks++;
    if (ndone !== 8) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 8", ndone);
    end
    tick();
    tick();
  endtask

  task automatic test_width1();
    logic a;
    logic b;
    int   sd;
    logic [2:0] exp;
    for (int i = 0; i < 4; i++) begin
      a  = 1'(i >> 1);
      b  = 1'(i);
      sd = (a ? -1 : 0) - (b ? -1 : 0);
      exp = {1'(int'(a) - int'(b)), (a < b), (sd > 0) || (sd < -1)};
      if1.a     = a;
      if1.b     = b;
      if1.start = 1'b1;
      tick();
      if1.start = 1'b0;
      if1.a     = ~a;
      if1.b     = ~b;
      checks++;
      if (if1.busy !== 1'b1) begin
        errors++;
        $display("FAIL w1_busy[%0d] got %b exp 1", i, if1.busy);
      end
      tick();
      checks++;
      if (if1.done !== 1'b1 ||
          {if1.diff, if1.borrow_out, if1.ovf} !== exp) begin
        errors++;
        $display("FAIL w1_result[%0d] done %b got %b exp %b", i, if1.done,
                 {if1.diff, if1.borrow_out, if1.ovf}, exp);
      end
      tick();
    end
  endtask

  initial begin
    if8.start = 1'b0;
    if8.a     = '0;
    if8.b     = '0;
    if1.start = 1'b0;
    if1.a     = '0;
    if1.b     = '0;
    test_reset();
    test_directed();
    test_ignore();
    test_abort();
    test_random();
    test_back_to_back();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
